input_debouncer: RTL and testbench

//  Upstream conditioning stage for the D flip-flop storage element. It takes a raw asynchronous

---
 rtl/input_debouncer.sv | 107 ++++++++++
 tb/tb_input_debouncer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Debouncer: synchronises a raw async input and accepts a change only after it persists.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a stable input change to dout.
// Backpressure: none; a single level stream is sampled every cycle, with en gating qualification.
module input_debouncer #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   CNT_W           = 16,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic din,
   output logic dout,
   output logic dout_b,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [0:0]       ST_STABLE = 1'b0;
   localparam logic [0:0]       ST_COUNT  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam bit               SINGLE    = (DEBOUNCE_CYCLES == 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;
   logic [0:0]             state_q, state_nxt;
   logic [CNT_W-1:0]       cnt_q, cnt_nxt, cnt_inc;
   logic                   dout_nxt;

   // Synchroniser runs every cycle so en only gates qualification, not sampling.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      end
   end

   assign sync_q  = sync_r[SYNC_STAGES-1];
   assign cnt_inc = cnt_q + CNT_ONE;

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      dout_nxt  = dout;
      if (!en) begin
         state_nxt = ST_STABLE;
         cnt_nxt   = '0;
      end else begin
         case (state_q)
            ST_STABLE: begin
               if (sync_q != dout) begin
                  if (SINGLE) begin
                     dout_nxt = sync_q;
                     cnt_nxt  = '0;
                  end else begin
                     cnt_nxt   = CNT_ONE;
                     state_nxt = ST_COUNT;
                  end
               end else begin
                  cnt_nxt = '0;
               end
            end
            ST_COUNT: begin
               if (sync_q == dout) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_STABLE;
               end else if (cnt_inc == CNT_LAST) begin
                  dout_nxt  = sync_q;
                  cnt_nxt   = '0;
                  state_nxt = ST_STABLE;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: begin
               cnt_nxt   = '0;
               state_nxt = ST_STABLE;
            end
         endcase
      end
   end

   // Pulses are derived from the registered transition so they align with the new dout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         dout    <= RESET_VAL;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         dout    <= dout_nxt;
         rise    <= dout_nxt & ~dout;
         fall    <= ~dout_nxt & dout;
      end
   end

   assign dout_b = ~dout;
   assign busy   = (state_q == ST_COUNT);

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus random stimulus, scoreboard-checked.
module tb_input_debouncer;

   localparam int   S  = 2;
   localparam int   N  = 4;
   localparam logic RV = 1'b0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic en = 1'b0;
   logic din = 1'b1;
   logic dout, dout_b, rise, fall, busy;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic dout;
      logic rise;
      logic fall;
      logic busy;
   } exp_t;

   exp_t expq[$];
   bit   dh[$];
   bit   eh[$];
   bit   vh[$];
   logic m_dout = RV;

   input_debouncer #(
      .SYNC_STAGES(S), .CNT_W(16), .DEBOUNCE_CYCLES(N), .RESET_VAL(RV)
   ) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .din(din),
      .dout(dout), .dout_b(dout_b), .rise(rise), .fall(fall), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: dout flips once the last N enabled samples of the synchronised
   // input all disagree with it; sync value is din delayed S edges since reset.
   task automatic model_push();
      exp_t x;
      bit   sb;
      bit   acc;
      logic old;
      x = '0;
      if (!reset_n) begin
         dh.delete(); eh.delete(); vh.delete();
         m_dout = RV;
         x.dout = RV;
      end else begin
         sb = (dh.size() >= S) ? dh[dh.size()-S] : RV;
         dh.push_back(din);
         eh.push_back(en);
         vh.push_back(sb);
         acc = (vh.size() >= N);
         if (acc) begin
            for (int k = vh.size() - N; k < vh.size(); k++) begin
               if (!eh[k] || (vh[k] == m_dout)) acc = 1'b0;
            end
         end
         old = m_dout;
         if (acc) m_dout = ~m_dout;
         x.dout = m_dout;
         x.rise = acc && (m_dout == 1'b1);
         x.fall = acc && (m_dout == 1'b0);
         x.busy = !acc && en && (sb != old);
         if (dh.size() > 64) begin
            void'(dh.pop_front()); void'(eh.pop_front()); void'(vh.pop_front());
         end
      end
      expq.push_back(x);
   endtask

   task automatic step(input logic r, input logic e, input logic d);
      @(negedge clk);
      if (!r && reset_n) begin
         reset_n = 1'b0; en = e; din = d;
         #1;
         chk("async_rst_dout", dout, RV);
         chk("async_rst_busy", busy, 1'b0);
         chk("async_rst_rise", rise, 1'b0);
      end else begin
         reset_n = r; en = e; din = d;
      end
      model_push();
   endtask

   // Caller has already driven the first stimulus edge; returns edges to change.
   task automatic measure(input logic target, input int exp_lat, input string name);
      int lat = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b1, 1'b1, target);
         if (dout == target) begin
            lat = i;
            if (target) chk({name, "_rise"}, rise, 1'b1);
            else        chk({name, "_fall"}, fall, 1'b1);
            break;
         end
      end
      chk_int({name, "_latency"}, lat, exp_lat);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("dout", dout, e.dout);
            chk("dout_b", dout_b, ~e.dout);
            chk("rise", rise, e.rise);
            chk("fall", fall, e.fall);
            chk("busy", busy, e.busy);
         end
      end
   end

   initial begin : stim
      int   run;
      logic v;
      // Held in reset with din=1.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
      // Short high glitch is rejected.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
      chk("glitch_dout", dout, 1'b0);
      chk("glitch_busy", busy, 1'b0);
      // Full rise.
      step(1'b1, 1'b1, 1'b1);
      measure(1'b1, S + N, "rise");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
      // Full fall.
      step(1'b1, 1'b1, 1'b0);
      measure(1'b0, S + N, "fall");
      chk("fall_dout_b", dout_b, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      // Disable mid-count, then re-enable.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
      for (int j = 0; j < 3; j++) begin
         step(1'b1, 1'b0, 1'b1);
         if (j > 0) chk("disabled_busy", busy, 1'b0);
      end
      step(1'b1, 1'b1, 1'b1);
      chk("disabled_busy_last", busy, 1'b0);
      measure(1'b1, N, "reenable");
      // Back to 0, then reset mid-count.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
      chk("pre_reset_busy", busy, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      measure(1'b1, S + N, "post_reset");
      // Random phase.
      for (int c = 0; c < 1500; ) begin
         v   = 1'($urandom_range(0, 1));
         run = $urandom_range(1, 8);
         for (int k = 0; k < run; k++) begin
            if ($urandom_range(0, 299) == 0) begin
               step(1'b0, 1'b1, v);
               step(1'b0, 1'b1, v);
               c += 2;
            end
            step(1'b1, ($urandom_range(0, 15) != 0), v);
            c++;
         end
      end
      @(posedge clk);
      #2;
      chk_int("queue_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
